// File: rtl/q2_io_panel_pkg.sv
// Shared definitions for the q2 front-panel peripheral: bus address, HD44780 codes,
// controller states and the small byte helpers used by the write path and the init sequence.
package q2_io_panel_pkg;

   localparam logic [11:0] IO_ADDR_DEF  = 12'hFFF;

   localparam logic [7:0]  LCD_FUNC_SET = 8'h38;
   localparam logic [7:0]  LCD_DISP_ON  = 8'h0C;
   localparam logic [7:0]  LCD_ENTRY    = 8'h06;
   localparam logic [7:0]  LCD_CLEAR    = 8'h01;
   localparam logic [7:0]  LCD_SET_ADDR = 8'h80;
   localparam logic [7:0]  SUBST_CHAR   = 8'h3F;
   localparam logic [7:0]  CHAR_MIN     = 8'h20;
   localparam logic [7:0]  CHAR_MAX     = 8'h7E;

   typedef enum logic [2:0] {
      ST_POR   = 3'd0,
      ST_IDLE  = 3'd1,
      ST_SETUP = 3'd2,
      ST_PULSE = 3'd3,
      ST_HOLD  = 3'd4
   } lcd_st_t;

   function automatic logic [7:0] init_code(input logic [1:0] idx);
      case (idx)
         2'd0:    init_code = LCD_FUNC_SET;
         2'd1:    init_code = LCD_DISP_ON;
         2'd2:    init_code = LCD_ENTRY;
         default: init_code = LCD_CLEAR;
      endcase
   endfunction

   // Characters the panel cannot show are replaced by '?'
   function automatic logic [7:0] printable(input logic [7:0] c);
      if ((c < CHAR_MIN) || (c > CHAR_MAX)) begin
         printable = SUBST_CHAR;
      end else begin
         printable = c;
      end
   endfunction

endpackage

// File: rtl/q2_io_fifo.sv
// Synchronous request FIFO for the LCD path; a push is accepted when full if a pop
// happens in the same cycle.
module q2_io_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wp_r, rp_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             do_pop_s, do_push_s;

   assign empty     = (wp_r == rp_r);
   assign full      = (wp_r[AW-1:0] == rp_r[AW-1:0]) && (wp_r[AW] != rp_r[AW]);
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);
   assign rdata     = mem_r[rp_r[AW-1:0]];

   // Read and write pointers, one extra wrap bit to tell full from empty
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_r <= {(AW+1){1'b0}};
         rp_r <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) wp_r <= wp_r + {{AW{1'b0}}, 1'b1};
         if (do_pop_s)  rp_r <= rp_r + {{AW{1'b0}}, 1'b1};
      end
   end

   // Storage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
      end else if (do_push_s) begin
         mem_r[wp_r[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/q2_io_panel.sv
// q2 front panel: CPU writes at IO_ADDR become queued, timed HD44780 transactions;
// CPU reads return queue status and debounced keys.
module q2_io_panel
   import q2_io_panel_pkg::*;
#(
   parameter logic [11:0] IO_ADDR   = IO_ADDR_DEF,
   parameter int          KEYS      = 4,
   parameter int          DEPTH     = 4,
   parameter int          E_CYC     = 1,
   parameter int          SHORT_CYC = 4,
   parameter int          LONG_CYC  = 160,
   parameter int          POR_CYC   = 4000,
   parameter int          DEB_CYC   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     abus,
   input  logic [11:0]     din,
   input  logic            wrm,
   input  logic            rdm,
   output logic [11:0]     dout,
   output logic            doe,
   input  logic [KEYS-1:0] key_n,
   output logic            lcd_rs,
   output logic            lcd_e,
   output logic [7:0]      lcd_d,
   output logic            busy
);
   localparam int TMAX = (POR_CYC > LONG_CYC) ? POR_CYC : LONG_CYC;
   localparam int CW   = $clog2(TMAX) + 1;
   localparam int DW   = $clog2(DEB_CYC) + 1;

   logic            wrm_q_r, rdm_q_r;
   logic            sel_s, wr_acc_s, rd_acc_s;
   logic            push_s, pop_s, full_s, empty_s;
   logic [8:0]      push_val_s, fifo_q_s;
   logic            ovf_r;
   logic [KEYS-1:0] ks1_r, ks2_r, key_deb_r;
   logic [DW-1:0]   kcnt_r [KEYS];
   lcd_st_t         st_r, st_nxt;
   logic [CW-1:0]   cnt_r, cnt_nxt, wait_s;
   logic [1:0]      idx_r, idx_nxt;
   logic            init_r, init_nxt;
   logic            ld_s;
   logic [8:0]      ld_val_s;
   logic            lcd_e_r, lcd_rs_r;
   logic [7:0]      lcd_d_r;

   assign sel_s    = (abus == IO_ADDR);
   assign wr_acc_s = wrm & ~wrm_q_r & sel_s;
   assign rd_acc_s = rdm & ~rdm_q_r & sel_s;
   assign doe      = rdm & sel_s;
   assign busy     = ~empty_s | (st_r != ST_IDLE);
   assign lcd_e    = lcd_e_r;
   assign lcd_rs   = lcd_rs_r;
   assign lcd_d    = lcd_d_r;
   assign wait_s   = (!lcd_rs_r && (lcd_d_r == LCD_CLEAR)) ? CW'(LONG_CYC - 1) : CW'(SHORT_CYC - 1);

   // Strobe history for edge-triggered bus accesses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrm_q_r <= 1'b0;
         rdm_q_r <= 1'b0;
      end else begin
         wrm_q_r <= wrm;
         rdm_q_r <= rdm;
      end
   end

   // Translate a CPU write word into a {rs,byte} queue entry
   always_comb begin
      push_s     = 1'b0;
      push_val_s = 9'h000;
      if (wr_acc_s) begin
         if (din[8]) begin
            if (din[7]) begin
               push_s     = 1'b1;
               push_val_s = {1'b0, LCD_SET_ADDR | {1'b0, din[6:0]}};
            end else if (din[0]) begin
               push_s     = 1'b1;
               push_val_s = {1'b0, LCD_CLEAR};
            end else begin
               push_s     = 1'b0;
            end
         end else begin
            push_s     = 1'b1;
            push_val_s = {1'b1, printable(din[7:0])};
         end
      end else begin
         push_s = 1'b0;
      end
   end

   q2_io_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .wdata (push_val_s),
      .pop   (pop_s),
      .rdata (fifo_q_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Sticky overflow; a new drop in the same cycle as a status read wins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_r <= 1'b0;
      end else if (push_s && full_s && !pop_s) begin
         ovf_r <= 1'b1;
      end else if (rd_acc_s) begin
         ovf_r <= 1'b0;
      end
   end

   // Status word read back by the CPU
   always_comb begin
      dout             = {12{1'b1}};
      dout[11]         = ~full_s;
      dout[10]         = ~ovf_r;
      dout[KEYS-1:0]   = key_deb_r;
   end

   // Two-flop synchroniser for the asynchronous keys
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ks1_r <= {KEYS{1'b1}};
         ks2_r <= {KEYS{1'b1}};
      end else begin
         ks1_r <= key_n;
         ks2_r <= ks1_r;
      end
   end

   // Per-key stability counter; a level is accepted after DEB_CYC differing cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_deb_r <= {KEYS{1'b1}};
         for (int k = 0; k < KEYS; k++) kcnt_r[k] <= {DW{1'b0}};
      end else begin
         for (int k = 0; k < KEYS; k++) begin
            if (ks2_r[k] == key_deb_r[k]) begin
               kcnt_r[k] <= {DW{1'b0}};
            end else if (kcnt_r[k] == DW'(DEB_CYC - 1)) begin
               key_deb_r[k] <= ks2_r[k];
               kcnt_r[k]    <= {DW{1'b0}};
            end else begin
               kcnt_r[k] <= kcnt_r[k] + DW'(1);
            end
         end
      end
   end

   // LCD controller next state; init steps reuse the SETUP/PULSE/HOLD path
   always_comb begin
      st_nxt   = st_r;
      cnt_nxt  = cnt_r;
      idx_nxt  = idx_r;
      init_nxt = init_r;
      pop_s    = 1'b0;
      ld_s     = 1'b0;
      ld_val_s = 9'h000;
      case (st_r)
         ST_POR: begin
            if (cnt_r == CW'(POR_CYC - 1)) begin
               st_nxt   = ST_SETUP;
               cnt_nxt  = {CW{1'b0}};
               idx_nxt  = 2'd0;
               init_nxt = 1'b1;
               ld_s     = 1'b1;
               ld_val_s = {1'b0, init_code(2'd0)};
            end else begin
               cnt_nxt = cnt_r + CW'(1);
            end
         end
         ST_IDLE: begin
            if (!empty_s) begin
               pop_s    = 1'b1;
               ld_s     = 1'b1;
               ld_val_s = fifo_q_s;
               st_nxt   = ST_SETUP;
            end else begin
               st_nxt = ST_IDLE;
            end
         end
         ST_SETUP: begin
            st_nxt  = ST_PULSE;
            cnt_nxt = {CW{1'b0}};
         end
         ST_PULSE: begin
            if (cnt_r == CW'(E_CYC - 1)) begin
               st_nxt  = ST_HOLD;
               cnt_nxt = {CW{1'b0}};
            end else begin
               cnt_nxt = cnt_r + CW'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_r == wait_s) begin
               cnt_nxt = {CW{1'b0}};
               if (init_r && (idx_r != 2'd3)) begin
                  idx_nxt  = idx_r + 2'd1;
                  ld_s     = 1'b1;
                  ld_val_s = {1'b0, init_code(idx_r + 2'd1)};
                  st_nxt   = ST_SETUP;
               end else begin
                  init_nxt = 1'b0;
                  st_nxt   = ST_IDLE;
               end
            end else begin
               cnt_nxt = cnt_r + CW'(1);
            end
         end
         default: begin
            st_nxt  = ST_POR;
            cnt_nxt = {CW{1'b0}};
         end
      endcase
   end

   // Controller state and registered LCD pins; rs/d only load on entry to SETUP
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_r     <= ST_POR;
         cnt_r    <= {CW{1'b0}};
         idx_r    <= 2'd0;
         init_r   <= 1'b0;
         lcd_e_r  <= 1'b0;
         lcd_rs_r <= 1'b0;
         lcd_d_r  <= 8'h00;
      end else begin
         st_r    <= st_nxt;
         cnt_r   <= cnt_nxt;
         idx_r   <= idx_nxt;
         init_r  <= init_nxt;
         lcd_e_r <= (st_nxt == ST_PULSE);
         if (ld_s) begin
            lcd_rs_r <= ld_val_s[8];
            lcd_d_r  <= ld_val_s[7:0];
         end
      end
   end

endmodule

// File: tb/tb_q2_io_panel.sv
// Bench for q2_io_panel: directed and random bus traffic against a queue of expected
// LCD transactions, plus key debounce checks.
module tb_q2_io_panel;
   localparam int DEB  = 16;
   localparam int LONG = 160;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] abus = 12'h000;
   logic [11:0] din  = 12'h000;
   logic        wrm  = 1'b0;
   logic        rdm  = 1'b0;
   logic [11:0] dout;
   logic        doe;
   logic [3:0]  key_n = 4'hF;
   logic        lcd_rs, lcd_e, busy;
   logic [7:0]  lcd_d;

   int          total = 0;
   int          bad   = 0;
   logic [8:0]  exp_q[$];
   logic        mon_en = 1'b0;
   logic [8:0]  cap = 9'h000;
   logic        last_clr = 1'b0;
   time         last_t = 0;

   always #5 clk = ~clk;

   q2_io_panel dut (
      .clk(clk), .rst(rst), .abus(abus), .din(din), .wrm(wrm), .rdm(rdm),
      .dout(dout), .doe(doe), .key_n(key_n), .lcd_rs(lcd_rs), .lcd_e(lcd_e),
      .lcd_d(lcd_d), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected LCD transaction for a CPU write word, -1 when nothing is sent
   function automatic int model(input logic [11:0] w);
      if (!w[8]) return (w[7:0] >= 8'h20 && w[7:0] <= 8'h7E) ? 256 + int'(w[7:0]) : 256 + 63;
      if (w[7]) return 128 + int'(w[6:0]);
      if (w[0]) return 1;
      return -1;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [11:0] a, input logic [11:0] d);
      @(negedge clk); abus = a; din = d; wrm = 1'b1;
      @(negedge clk); wrm = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, output logic [11:0] v, output logic oe);
      @(negedge clk); abus = a; rdm = 1'b1;
      #1; v = dout; oe = doe;
      @(negedge clk); rdm = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      for (int i = 0; i < lim && busy; i++) @(negedge clk);
      chk("idle_reached", 32'(busy), 32'd0);
   endtask

   task automatic wait_e(input int lim);
      for (int i = 0; i < lim && !lcd_e; i++) begin
         @(posedge clk); #1;
      end
      chk("e_seen", 32'(lcd_e), 32'd1);
   endtask

   // Every strobe must match the next expected transaction; clears need the long wait
   always @(posedge lcd_e) begin
      if (mon_en) begin
         chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("pulse_value", {23'd0, lcd_rs, lcd_d}, {23'd0, exp_q.pop_front()});
         if (last_clr) chk("clear_wait", 32'((($time - last_t) / 10) >= LONG), 32'd1);
         cap      = {lcd_rs, lcd_d};
         last_clr = (cap == 9'h001);
         last_t   = $time;
      end
   end

   always @(negedge lcd_e) begin
      if (mon_en && rst) chk("hold_stable", {23'd0, lcd_rs, lcd_d}, {23'd0, cap});
   end

   initial begin
      logic [11:0] v;
      logic        oe;
      logic [11:0] w;
      logic [3:0]  ka, kg;
      logic        bad_a;
      int          m;

      #2 rst = 1'b0;
      cyc(3);
      chk("rst_e", 32'(lcd_e), 32'd0);
      chk("rst_rs", 32'(lcd_rs), 32'd0);
      chk("rst_d", 32'(lcd_d), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      rd(12'hFFF, v, oe);
      chk("rst_dout", 32'(v), 32'hFFF);
      chk("rst_doe", 32'(oe), 32'd1);

      @(negedge clk); rst = 1'b1; mon_en = 1'b1;
      exp_q = '{9'h038, 9'h00C, 9'h006, 9'h001};
      wr(12'hFFF, 12'h048); exp_q.push_back(9'h148);
      wait_idle(6000);
      chk("init_drained", 32'(exp_q.size()), 32'd0);

      wr(12'hFFF, 12'h041); exp_q.push_back(9'h141); wait_idle(200);
      wr(12'hFFF, 12'h005); exp_q.push_back(9'h13F); wait_idle(200);
      wr(12'hFFF, 12'h1A5); exp_q.push_back(9'h0A5); wait_idle(200);
      wr(12'hFFF, 12'h101); exp_q.push_back(9'h001); wait_idle(400);
      wr(12'hFFF, 12'h102); cyc(2);
      chk("ignored_busy", 32'(busy), 32'd0);
      wr(12'hFFE, 12'h041); cyc(2);
      chk("badaddr_busy", 32'(busy), 32'd0);
      rd(12'hFFE, v, oe);
      chk("badaddr_doe", 32'(oe), 32'd0);
      chk("directed_drained", 32'(exp_q.size()), 32'd0);

      // Five writes while a clear is holding: four fit, the fifth is dropped
      wr(12'hFFF, 12'h101); exp_q.push_back(9'h001);
      wait_e(20);
      for (int i = 0; i < 5; i++) begin
         wr(12'hFFF, 12'(12'h030 + i));
         if (i < 4) exp_q.push_back(9'(9'h130 + i));
      end
      rd(12'hFFF, v, oe);
      chk("ovf_flag", 32'(v[10]), 32'd0);
      chk("full_flag", 32'(v[11]), 32'd0);
      rd(12'hFFF, v, oe);
      chk("ovf_clr", 32'(v[10]), 32'd1);
      wait_idle(600);
      chk("ovf_drained", 32'(exp_q.size()), 32'd0);

      key_n = 4'h7; cyc(DEB + 2);
      rd(12'hFFF, v, oe);
      chk("key3_dout", 32'(v), 32'hFF7);
      chk("key3_doe", 32'(oe), 32'd1);
      key_n = 4'hF; cyc(DEB + 4);
      rd(12'hFFF, v, oe);
      chk("key_release", 32'(v), 32'hFFF);
      key_n = 4'h7; cyc(8);
      rd(12'hFFF, v, oe);
      chk("key_glitch", 32'(v), 32'hFFF);
      key_n = 4'hF; cyc(DEB + 4);

      for (int i = 0; i < 8; i++) begin
         ka = 4'($urandom); key_n = ka; cyc(DEB + 4);
         rd(12'hFFF, v, oe);
         chk("key_hold", 32'(v), {20'd0, 8'hFF, ka});
         kg = 4'($urandom); key_n = kg; cyc(int'($urandom_range(DEB - 7, 0)));
         rd(12'hFFF, v, oe);
         chk("key_short", 32'(v), {20'd0, 8'hFF, ka});
      end
      key_n = 4'hF; cyc(DEB + 4);

      for (int i = 0; i < 30; i++) begin
         w     = 12'($urandom);
         bad_a = ($urandom_range(7, 0) == 0);
         wr(bad_a ? 12'hFFE : 12'hFFF, w);
         m = model(w);
         if (!bad_a && m >= 0) exp_q.push_back(9'(m));
         wait_idle(400);
      end
      chk("rand_drained", 32'(exp_q.size()), 32'd0);

      // Reset while the strobe is high must drop it at once
      wr(12'hFFF, 12'h041); exp_q.push_back(9'h141);
      wait_e(20);
      rst = 1'b0;
      #1;
      chk("abort_e", 32'(lcd_e), 32'd0);
      chk("abort_busy", 32'(busy), 32'd1);
      cyc(2); rst = 1'b1; cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
